// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer.
package cpu_sequencer_pkg;

    // Sequencer state, exported on state_o.
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5,
        FAULT     = 3'd6
    } seq_state_t;

    // Next-PC source selected during writeback.
    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_ALU    = 2'd2
    } pc_sel_t;

    // Register-file writeback source.
    typedef enum logic [1:0] {
        RD_ALU = 2'd0,
        RD_MEM = 2'd1,
        RD_PC4 = 2'd2
    } rd_src_t;

    // True in the states that hold a memory request open.
    function automatic logic is_wait_state(seq_state_t s);
        return (s == FETCH) || (s == MEMORY);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction/data memory handshake bundle between the sequencer and the memory side.
interface cpu_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic ir_we;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface

// File: rtl/cpu_sequencer_handshake_timeout.sv
// Wait counter shared by the fetch and data-memory handshakes.
// cnt_q holds the number of unanswered request cycles seen so far. expired_o
// flags the cycle that would be the LIMIT-th unanswered one, so the owner can
// leave for its fault state on that edge; an ack in that cycle keeps enable_i
// low and therefore wins. LIMIT = 0 disables expiry entirely.
module handshake_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);
    localparam logic ENABLED = (LIMIT > 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = ENABLED & enable_i & (cnt_q == LAST);

    // Next count: clear on request entry/ack, otherwise count unanswered cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the single-issue RV32I core.
//
// state     | meaning
// ----------+---------------------------------------------------------
// FETCH     | imem_req held until imem_ack; ir_we pulses with the ack
// DECODE    | one cycle; illegal instruction faults
// EXECUTE   | one cycle of ALU; loads/stores go on to MEMORY
// MEMORY    | dmem_req (and dmem_we for stores) held until dmem_ack
// WRITEBACK | rf/pc strobes, instret++, halt_req sampled here only
// HALTED    | parked at an instruction boundary until halt_req drops
// FAULT     | sticky; left only through reset
//
// Strobes are forced low while rst_n is held so that an in-flight request is
// dropped immediately rather than at the next clock edge.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_sequencer_if.master      bus,
    input  logic                 dec_load_memory,
    input  logic                 dec_store_memory,
    input  logic                 dec_conditional_jump,
    input  logic                 dec_unconditional_jump,
    input  logic                 dec_reg_we,
    input  logic                 dec_illegal,
    input  logic                 branch_taken,
    output logic                 rf_we,
    output logic [1:0]           rd_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 fault,
    output logic [2:0]           state_o,
    output logic [INSTRET_W-1:0] instret
);
    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] instret_d;

    logic    imem_req_c;
    logic    ir_we_c;
    logic    dmem_req_c;
    logic    dmem_we_c;
    logic    rf_we_c;
    logic    pc_we_c;
    rd_src_t rd_sel_c;
    pc_sel_t pc_sel_c;
    logic    halted_c;
    logic    fault_c;

    logic in_wait;
    logic ack_cur;
    logic wait_expired;

    assign in_wait = is_wait_state(state_q);
    assign ack_cur = ((state_q == FETCH)  & bus.imem_ack)
                   | ((state_q == MEMORY) & bus.dmem_ack);

    handshake_timeout #(
        .LIMIT (MEM_TIMEOUT)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (~in_wait | ack_cur),
        .enable_i  (in_wait & ~ack_cur),
        .expired_o (wait_expired)
    );

    // Next-state and output decode from the current state and decoder flags.
    always_comb begin
        state_d    = state_q;
        instret_d  = instret_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        rd_sel_c   = RD_ALU;
        pc_sel_c   = PC_PLUS4;
        halted_c   = 1'b0;
        fault_c    = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                state_d = dec_illegal ? FAULT : EXECUTE;
            end
            EXECUTE: begin
                state_d = (dec_load_memory | dec_store_memory) ? MEMORY : WRITEBACK;
            end
            MEMORY: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = dec_store_memory;
                if (bus.dmem_ack) begin
                    state_d = WRITEBACK;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            WRITEBACK: begin
                rf_we_c = dec_reg_we & ~dec_store_memory & ~dec_conditional_jump;
                pc_we_c = 1'b1;
                if (dec_load_memory) begin
                    rd_sel_c = RD_MEM;
                end else if (dec_unconditional_jump) begin
                    rd_sel_c = RD_PC4;
                end
                if (dec_unconditional_jump) begin
                    pc_sel_c = PC_ALU;
                end else if (dec_conditional_jump && branch_taken) begin
                    pc_sel_c = PC_BRANCH;
                end
                instret_d = instret_q + 1'b1;
                state_d   = halt_req ? HALTED : FETCH;
            end
            HALTED: begin
                halted_c = 1'b1;
                if (!halt_req) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                fault_c = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // State and retired-instruction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.imem_req = imem_req_c & rst_n;
    assign bus.ir_we    = ir_we_c    & rst_n;
    assign bus.dmem_req = dmem_req_c & rst_n;
    assign bus.dmem_we  = dmem_we_c  & rst_n;
    assign rf_we        = rf_we_c    & rst_n;
    assign pc_we        = pc_we_c    & rst_n;
    assign rd_sel       = rd_sel_c;
    assign pc_sel       = pc_sel_c;
    assign halted       = halted_c;
    assign fault        = fault_c;
    assign state_o      = state_q;
    assign instret      = instret_q;
endmodule
